// File: rtl/sort_uart_pkg.sv
// Shared types and default sizing for the UART-fed sort controller.
package sort_uart_pkg;

    localparam int unsigned N_WORDS_DEF = 8;
    localparam int unsigned W_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        SEND = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/sort_tx_streamer.sv
// Streams elements 0..count-1 of a captured frame to a valid/ready byte sink.
module sort_tx_streamer
    import sort_uart_pkg::*;
#(
    parameter int unsigned N_WORDS = N_WORDS_DEF,
    parameter int unsigned W       = W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(N_WORDS):0]     count,
    input  logic [N_WORDS*W-1:0]         frame,
    input  logic                         tx_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    output logic                         last_c
);

    localparam int unsigned IW = $clog2(N_WORDS);
    localparam int unsigned CW = IW + 1;

    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic          valid_nxt;
    logic [7:0]    data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            idx      <= idx_nxt;
            tx_valid <= valid_nxt;
            tx_data  <= data_nxt;
        end
    end

    // tx_data only moves on start or an accepted handshake, so it holds under backpressure
    always_comb begin
        idx_nxt   = idx;
        valid_nxt = tx_valid;
        data_nxt  = tx_data;
        last_c    = 1'b0;
        if (start) begin
            idx_nxt   = '0;
            valid_nxt = 1'b1;
            data_nxt  = 8'(frame[W-1:0]);
        end else if (tx_valid && tx_ready) begin
            if ({1'b0, idx} == count - CW'(1)) begin
                valid_nxt = 1'b0;
                last_c    = 1'b1;
            end else begin
                idx_nxt  = idx + IW'(1);
                data_nxt = 8'(frame[idx_nxt*W +: W]);
            end
        end
    end

endmodule

// File: rtl/sort_uart_ctrl.sv
// Collects a UART byte frame, hands it to an external sorter and streams the
// sorted result back out, padding short frames with all-ones elements.
module sort_uart_ctrl
    import sort_uart_pkg::*;
#(
    parameter int unsigned N_WORDS = N_WORDS_DEF,
    parameter int unsigned W       = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_end,
    output logic                 sort_start,
    output logic [N_WORDS*W-1:0] sort_in,
    input  logic                 sort_done,
    input  logic [N_WORDS*W-1:0] sort_out,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned IW = $clog2(N_WORDS);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned FW = N_WORDS * W;

    ctrl_state_t   state;
    ctrl_state_t   state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] cnt_upd;
    logic [FW-1:0] frame;
    logic [FW-1:0] frame_nxt;
    logic          overrun_nxt;
    logic          sort_start_nxt;
    logic          send_go;
    logic          send_go_nxt;
    logic          busy_nxt;
    logic          tx_last_c;

    assign sort_in = frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            frame      <= '0;
            overrun    <= 1'b0;
            sort_start <= 1'b0;
            send_go    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            frame      <= frame_nxt;
            overrun    <= overrun_nxt;
            sort_start <= sort_start_nxt;
            send_go    <= send_go_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        frame_nxt      = frame;
        overrun_nxt    = overrun;
        sort_start_nxt = 1'b0;
        send_go_nxt    = 1'b0;
        cnt_upd        = count;
        case (state)
            IDLE, LOAD: begin
                if (state == IDLE) begin
                    cnt_upd = '0;
                end
                // a coincident byte is stored before the end-of-frame decision
                if (rx_valid) begin
                    frame_nxt[cnt_upd[IW-1:0]*W +: W] = W'(rx_data);
                    cnt_upd = cnt_upd + CW'(1);
                end
                if (state == LOAD || rx_valid) begin
                    state_nxt = LOAD;
                    count_nxt = cnt_upd;
                    if (state == IDLE) begin
                        overrun_nxt = 1'b0;
                    end
                    if (cnt_upd == CW'(N_WORDS)) begin
                        state_nxt      = SORT;
                        sort_start_nxt = 1'b1;
                    end else if (rx_end) begin
                        for (int unsigned i = 0; i < N_WORDS; i++) begin
                            if (CW'(i) >= cnt_upd) begin
                                frame_nxt[i*W +: W] = '1;
                            end
                        end
                        state_nxt      = SORT;
                        sort_start_nxt = 1'b1;
                    end
                end
            end
            SORT: begin
                if (rx_valid) begin
                    overrun_nxt = 1'b1;
                end
                if (sort_done) begin
                    frame_nxt   = sort_out;
                    state_nxt   = SEND;
                    send_go_nxt = 1'b1;
                end
            end
            SEND: begin
                if (rx_valid) begin
                    overrun_nxt = 1'b1;
                end
                if (tx_last_c) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    sort_tx_streamer #(
        .N_WORDS (N_WORDS),
        .W       (W)
    ) u_streamer (
        .clk      (clk),
        .rst      (rst),
        .start    (send_go),
        .count    (count),
        .frame    (frame),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .last_c   (tx_last_c)
    );

endmodule

// File: tb/tb_sort_uart_ctrl.sv
// Directed bench for sort_uart_ctrl with a stub sorter and a byte sink.
module tb_sort_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_end;
    logic        sort_start;
    logic [63:0] sort_in;
    logic        sort_done;
    logic [63:0] sort_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    sort_uart_ctrl #(.N_WORDS(8), .W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_end     (rx_end),
        .sort_start (sort_start),
        .sort_in    (sort_in),
        .sort_done  (sort_done),
        .sort_out   (sort_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // byte sink: record every accepted handshake
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) got_q.push_back(tx_data);
    end

    // stub sorter: answers 4 cycles after sort_start with the sorted frame
    initial begin
        logic [7:0] a [8];
        logic [7:0] t;
        sort_done = 1'b0;
        sort_out  = '0;
        forever begin
            @(negedge clk);
            if (sort_start === 1'b1) begin
                for (int i = 0; i < 8; i++) a[i] = sort_in[i*8 +: 8];
                for (int i = 0; i < 7; i++)
                    for (int j = 0; j < 7 - i; j++)
                        if (a[j] > a[j+1]) begin
                            t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                        end
                for (int i = 0; i < 8; i++) sort_out[i*8 +: 8] = a[i];
                repeat (4) @(posedge clk);
                #1 sort_done = 1'b1;
                @(posedge clk);
                #1 sort_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_end);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_end   = with_end;
        tick();
        rx_valid = 1'b0;
        rx_end   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_idle_in_time"}, 64'(n < 300), 64'd1);
        check({tag, "_tx_valid_low"}, 64'(tx_valid), 64'd0);
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_tx_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_tx%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_end = 1'b0; tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_sort_start", 64'(sort_start), 64'd0);
        check("rst_sort_in", sort_in, 64'd0);
        rst = 1'b0;
        tick();

        // rx_end alone in IDLE is ignored
        rx_end = 1'b1; tick(); rx_end = 1'b0;
        check("idle_end_busy", 64'(busy), 64'd0);
        tick();
        check("idle_end_no_start", 64'(sort_start), 64'd0);

        // full frame
        got_q.delete();
        send_byte(8'h05, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h07, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h08, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h06, 1'b0);
        check("full_busy_load", 64'(busy), 64'd1);
        check("full_no_early_start", 64'(sort_start), 64'd0);
        send_byte(8'h04, 1'b0);
        check("full_sort_start", 64'(sort_start), 64'd1);
        check("full_sort_in", sort_in, 64'h0406020801070305);
        tick();
        check("full_start_pulse", 64'(sort_start), 64'd0);
        wait_idle("full");
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        compare_out("full");

        // short frame padded with all-ones
        got_q.delete();
        send_byte(8'h09, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h05, 1'b0);
        rx_end = 1'b1; tick(); rx_end = 1'b0;
        check("short_sort_start", 64'(sort_start), 64'd1);
        check("short_sort_in", sort_in, 64'hFFFFFFFFFF050209);
        wait_idle("short");
        exp_q = '{8'h02, 8'h05, 8'h09};
        compare_out("short");

        // backpressure on the second byte
        got_q.delete();
        send_byte(8'h17, 1'b0); send_byte(8'h16, 1'b0); send_byte(8'h15, 1'b0);
        send_byte(8'h14, 1'b0); send_byte(8'h13, 1'b0); send_byte(8'h12, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h10, 1'b0);
        begin
            int n = 0;
            while (got_q.size() < 1 && n < 100) begin tick(); n++; end
            check("bp_first_accept", 64'(n < 100), 64'd1);
        end
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 64'(tx_valid), 64'd1);
            check("bp_hold_data", 64'(tx_data), 64'h11);
        end
        tx_ready = 1'b1;
        wait_idle("bp");
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        compare_out("bp");

        // overrun during SORT
        got_q.delete();
        send_byte(8'h21, 1'b0); send_byte(8'h28, 1'b0); send_byte(8'h22, 1'b0);
        send_byte(8'h27, 1'b0); send_byte(8'h23, 1'b0); send_byte(8'h26, 1'b0);
        send_byte(8'h24, 1'b0); send_byte(8'h25, 1'b0);
        check("ovr_sort_start", 64'(sort_start), 64'd1);
        send_byte(8'hAA, 1'b0);
        check("ovr_set", 64'(overrun), 64'd1);
        check("ovr_frame_kept", sort_in, 64'h2524262327222821);
        wait_idle("ovr");
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        compare_out("ovr");
        check("ovr_sticky", 64'(overrun), 64'd1);

        // next frame clears overrun, then reset mid-LOAD after 4 bytes
        got_q.delete();
        send_byte(8'h99, 1'b0);
        check("ovr_cleared", 64'(overrun), 64'd0);
        send_byte(8'h98, 1'b0); send_byte(8'h97, 1'b0); send_byte(8'h96, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sort_in", sort_in, 64'd0);
        send_byte(8'h38, 1'b0); send_byte(8'h31, 1'b0); send_byte(8'h37, 1'b0);
        send_byte(8'h32, 1'b0); send_byte(8'h36, 1'b0); send_byte(8'h33, 1'b0);
        send_byte(8'h35, 1'b0); send_byte(8'h34, 1'b0);
        check("midrst_sort_in_new", sort_in, 64'h3435333632373138);
        wait_idle("midrst");
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        compare_out("midrst");

        // coincident rx_valid + rx_end on the third byte
        got_q.delete();
        send_byte(8'h42, 1'b0); send_byte(8'h40, 1'b0);
        send_byte(8'h41, 1'b1);
        check("coin_sort_start", 64'(sort_start), 64'd1);
        check("coin_sort_in", sort_in, 64'hFFFFFFFFFF414042);
        wait_idle("coin");
        exp_q = '{8'h40, 8'h41, 8'h42};
        compare_out("coin");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
